// File: rtl/instr_byte_queue_pkg.sv
// Shared definitions for the instruction byte queue and the compute unit:
// opcode values, instruction field layout, legality check and assembly phases.
package instr_byte_queue_pkg;

  localparam int unsigned FIELD_W = 4;
  localparam int unsigned INSTR_W = 4 * FIELD_W;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [FIELD_W-1:0] OP_LOAD = 4'b1001;
  localparam logic [FIELD_W-1:0] OP_ADD  = 4'b1010;
  localparam logic [FIELD_W-1:0] OP_SUB  = 4'b1011;
  localparam logic [FIELD_W-1:0] OP_AND  = 4'b1100;
  localparam logic [FIELD_W-1:0] OP_OR   = 4'b1101;
  localparam logic [FIELD_W-1:0] OP_NOT  = 4'b1110;
  localparam logic [FIELD_W-1:0] OP_XOR  = 4'b1111;

  // Instruction layout: opcode[15:12], tgt[11:8], src0[7:4], src1[3:0]
  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] tgt;
    logic [FIELD_W-1:0] src0;
    logic [FIELD_W-1:0] src1;
  } instr_t;

  // Byte assembly phase: high byte expected first, then low byte
  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

  function automatic logic is_legal_opcode(input logic [FIELD_W-1:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_LOAD, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_NOT, OP_XOR: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_byte_queue_sync_fifo.sv
// Synchronous FIFO with registered occupancy count. Power-of-two depth so
// pointers wrap naturally. clr_i empties the FIFO and beats push/pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state for pointers and count; clear wins over any transfer
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers and storage write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_byte_queue.sv
// Assembles 16-bit instructions from a high-byte-first byte stream, drops
// illegal opcodes (counting them), and queues legal ones for the compute unit.
module instr_byte_queue
  import instr_byte_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    flush,
  output logic [15:0]             instr_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic                    phase
);

  phase_e                phase_q, phase_d;
  logic [7:0]            hi_q, hi_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  instr_t                word;
  logic                  accept, lo_accept, legal;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;

  // Handshake decode; byte_ready looks only at registered FIFO fullness
  always_comb begin
    byte_ready = (phase_q == PH_HI) | ~fifo_full;
    accept     = byte_valid & byte_ready;
    lo_accept  = accept & (phase_q == PH_LO);
    word       = {hi_q, byte_in};
    legal      = is_legal_opcode(word.opcode);
    push       = lo_accept & legal & ~flush;
    pop        = instr_valid & instr_ready & ~flush;
  end

  // Assembly FSM next state and high-byte capture
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (flush) begin
      phase_d = PH_HI;
      hi_d    = '0;
    end else if (accept) begin
      case (phase_q)
        PH_HI: begin
          hi_d    = byte_in;
          phase_d = PH_LO;
        end
        PH_LO:   phase_d = PH_HI;
        default: phase_d = PH_HI;
      endcase
    end
  end

  // Saturating illegal-opcode counter; a flushed low byte is not counted
  always_comb begin
    drop_d = drop_q;
    if (lo_accept && !legal && !flush && !(&drop_q))
      drop_d = drop_q + DROP_CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_HI;
      hi_q    <= '0;
      drop_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (word),
    .rdata_o (instr_out),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign drop_count  = drop_q;
  assign phase       = (phase_q == PH_LO);

endmodule

// File: tb/tb_instr_byte_queue.sv
// Scoreboard bench for instr_byte_queue: a queue-level reference model pushes
// expected instructions; a negedge monitor pops and compares on handshakes.
module tb_instr_byte_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int DMAX  = (1 << DW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        flush = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;
  logic        phase;

  instr_byte_queue #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending words plus occupancy/phase/drop state
  bit [15:0] sb[$];
  int        m_cnt   = 0;
  bit        m_phase = 1'b0;
  bit [7:0]  m_hi    = '0;
  int        m_drop  = 0;

  always @(posedge clk) begin : model
    bit        br, pop_e, push_e;
    bit [15:0] w;
    if (rst) begin
      sb.delete(); m_cnt = 0; m_phase = 0; m_hi = '0; m_drop = 0;
    end else if (flush) begin
      sb.delete(); m_cnt = 0; m_phase = 0; m_hi = '0;
    end else begin
      br     = !m_phase || (m_cnt < DEPTH);
      pop_e  = instr_ready && (m_cnt > 0);
      push_e = 0;
      if (byte_valid && br) begin
        if (!m_phase) begin
          m_hi = byte_in; m_phase = 1;
        end else begin
          w = {m_hi, byte_in};
          m_phase = 0;
          if (w[15:12] == 4'd0 || w[15:12] >= 4'd9) begin
            push_e = 1; sb.push_back(w);
          end else if (m_drop < DMAX) begin
            m_drop++;
          end
        end
      end
      m_cnt = m_cnt + int'(push_e) - int'(pop_e);
    end
  end

  // Monitor: status against model, head against scoreboard on handshake
  always @(negedge clk) begin : monitor
    chk("byte_ready", 32'(byte_ready), 32'(!m_phase || (m_cnt < DEPTH)));
    chk("instr_valid", 32'(instr_valid), 32'(m_cnt != 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("phase", 32'(phase), 32'(m_phase));
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_empty: got %0h expected no valid head at %0t", instr_out, $time);
      end else begin
        chk("instr_out", 32'(instr_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  // Present a byte until accepted (bounded), leaving byte_valid low afterwards
  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #2;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", b);
    end
    byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] legal_hi();
    logic [3:0] op;
    op = 4'($urandom_range(8, 15));
    if (op == 4'd8) op = 4'd0;
    return {op, 4'($urandom_range(0, 15))};
  endfunction

  task automatic drain(input int n);
    instr_ready = 1'b1;
    repeat (n) sync();
    instr_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hb;
    // Reset state
    @(posedge clk); #2;
    peek();
    chk("rst_instr_out", 32'(instr_out), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_ready", 32'(byte_ready), 32'h1);
    chk("rst_count", 32'(fifo_count), 32'h0);
    sync();
    rst = 1'b0;

    // First instruction
    send_byte(8'h91);
    send_byte(8'h2A);
    peek();
    chk("first_valid", 32'(instr_valid), 32'h1);
    chk("first_out", 32'(instr_out), 32'h912A);
    chk("first_count", 32'(fifo_count), 32'h1);
    chk("first_drop", 32'(drop_count), 32'h0);
    sync();
    drain(1);

    // Illegal opcode drop and saturation
    send_byte(8'h31);
    send_byte(8'h00);
    peek();
    chk("drop_one", 32'(drop_count), 32'h1);
    chk("drop_novalid", 32'(instr_valid), 32'h0);
    sync();
    repeat (299) begin
      send_byte(8'h31);
      send_byte(8'h00);
    end
    peek();
    chk("drop_sat", 32'(drop_count), 32'hFF);
    sync();

    // Fill to DEPTH, stall the fifth low byte, release with one pop
    for (int i = 0; i < 4; i++) begin
      hb = 8'h9C + 8'(i) * 8'h10;
      send_byte(hb);
      send_byte(8'h10 + 8'(i));
    end
    send_byte(8'hDC);
    byte_valid = 1'b1;
    byte_in    = 8'h14;
    repeat (2) begin
      peek();
      chk("full_stall_ready", 32'(byte_ready), 32'h0);
      chk("full_count", 32'(fifo_count), 32'h4);
      sync();
    end
    instr_ready = 1'b1;
    sync();
    instr_ready = 1'b0;
    peek();
    chk("release_ready", 32'(byte_ready), 32'h1);
    chk("release_count", 32'(fifo_count), 32'h3);
    sync();
    send_byte(8'h14);
    peek();
    chk("refill_count", 32'(fifo_count), 32'h4);
    sync();
    drain(6);

    // Continuous streaming with the consumer always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(legal_hi());
      send_byte(8'($urandom));
      chk("stream_count_le1", 32'(fifo_count <= 3'd1), 32'h1);
    end
    repeat (2) sync();
    instr_ready = 1'b0;

    // Flush beats a pending low-byte accept and a pop
    send_byte(8'hC1); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h0F);
    send_byte(8'hA1);
    byte_valid  = 1'b1;
    byte_in     = 8'h77;
    instr_ready = 1'b1;
    flush       = 1'b1;
    sync();
    flush       = 1'b0;
    byte_valid  = 1'b0;
    instr_ready = 1'b0;
    peek();
    chk("flush_count", 32'(fifo_count), 32'h0);
    chk("flush_valid", 32'(instr_valid), 32'h0);
    chk("flush_phase", 32'(phase), 32'h0);
    chk("flush_drop", 32'(drop_count), 32'hFF);
    sync();
    send_byte(8'hC3);
    send_byte(8'h45);
    peek();
    chk("post_flush_out", 32'(instr_out), 32'hC345);
    sync();
    drain(2);

    // Reset mid-instruction with entries queued
    send_byte(8'hB1); send_byte(8'h11);
    send_byte(8'hB2); send_byte(8'h22);
    send_byte(8'hB3); send_byte(8'h33);
    send_byte(8'hE4);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    peek();
    chk("rst2_phase", 32'(phase), 32'h0);
    chk("rst2_ready", 32'(byte_ready), 32'h1);
    chk("rst2_valid", 32'(instr_valid), 32'h0);
    chk("rst2_count", 32'(fifo_count), 32'h0);
    chk("rst2_drop", 32'(drop_count), 32'h0);
    chk("rst2_out", 32'(instr_out), 32'h0);
    sync();
    send_byte(8'h95);
    send_byte(8'h01);
    peek();
    chk("rst2_restart_out", 32'(instr_out), 32'h9501);
    sync();
    drain(2);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      byte_valid  = ($urandom_range(0, 3) != 0);
      byte_in     = ($urandom_range(0, 1) != 0) ? legal_hi() : 8'($urandom);
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      sync();
    end
    byte_valid = 1'b0;
    flush      = 1'b0;
    rst        = 1'b0;
    drain(8);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
